// File: rtl/axi4lite_csr_adapter.sv
// axi4lite_csr_adapter: AXI4-Lite slave front-end that turns accepted AW/W or AR
// transactions into single-outstanding native CSR requests and returns the CSR
// completion as a B or R response.
// Optional feature macro: AXI4LITE_CSR_TIMEOUT_EN enables a CSR ack timeout of
// TIMEOUT_CYCLES csr_req cycles that completes the transaction with SLVERR.
module axi4lite_csr_adapter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic [2:0]                s_awprot,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic [2:0]                s_arprot,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic                      csr_req,
    output logic                      csr_req_is_wr,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    output logic [DATA_WIDTH-1:0]     csr_wr_data,
    output logic [DATA_WIDTH-1:0]     csr_wr_biten,
    input  logic                      csr_ack,
    input  logic                      csr_err,
    input  logic [DATA_WIDTH-1:0]     csr_rd_data
);

    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CSR_WR  = 3'd1;
    localparam logic [2:0] ST_CSR_RD  = 3'd2;
    localparam logic [2:0] ST_WR_RESP = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;

    // Expand byte strobes into a per-bit enable mask.
    function automatic logic [DATA_WIDTH-1:0] f_strb_to_biten(input logic [STRB_W-1:0] strb);
        logic [DATA_WIDTH-1:0] v;
        v = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < STRB_W; i++) begin
            v[8*i +: 8] = {8{strb[i]}};
        end
        return v;
    endfunction

    logic                      r_aw_full, r_w_full, r_ar_full;
    logic                      r_awready, r_wready, r_arready;
    logic [CSR_ADDR_WIDTH-3:0] r_aw_addr, r_ar_addr;
    logic [DATA_WIDTH-1:0]     r_w_data;
    logic [STRB_W-1:0]         r_w_strb;
    logic [2:0]                r_state;
    logic                      r_prio_rd;
    logic                      r_csr_req, r_csr_is_wr;
    logic [CSR_ADDR_WIDTH-1:0] r_csr_addr;
    logic [DATA_WIDTH-1:0]     r_csr_wr_data, r_csr_biten;
    logic                      r_bvalid, r_rvalid;
    logic [1:0]                r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0]     r_rdata;

    logic w_aw_cap, w_w_cap, w_ar_cap;
    logic w_wr_pend, w_rd_pend;
    logic w_grant_wr, w_grant_rd;
    logic w_aw_full_nxt, w_w_full_nxt, w_ar_full_nxt;
    logic w_tmo_expire, w_fin, w_slverr;

    assign w_aw_cap  = s_awvalid & r_awready;
    assign w_w_cap   = s_wvalid & r_wready;
    assign w_ar_cap  = s_arvalid & r_arready;
    assign w_wr_pend = r_aw_full & r_w_full;
    assign w_rd_pend = r_ar_full;

    // Grant decision in IDLE: alternate priority when write and read both wait.
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_wr_pend && w_rd_pend) begin
                if (r_prio_rd) begin
                    w_grant_rd = 1'b1;
                end else begin
                    w_grant_wr = 1'b1;
                end
            end else if (w_wr_pend) begin
                w_grant_wr = 1'b1;
            end else if (w_rd_pend) begin
                w_grant_rd = 1'b1;
            end else begin
                w_grant_wr = 1'b0;
                w_grant_rd = 1'b0;
            end
        end else begin
            w_grant_wr = 1'b0;
            w_grant_rd = 1'b0;
        end
    end

    // A holding reg can never capture and be granted on the same edge, since
    // capture needs it empty and grant needs it full.
    assign w_aw_full_nxt = w_aw_cap ? 1'b1 : (w_grant_wr ? 1'b0 : r_aw_full);
    assign w_w_full_nxt  = w_w_cap  ? 1'b1 : (w_grant_wr ? 1'b0 : r_w_full);
    assign w_ar_full_nxt = w_ar_cap ? 1'b1 : (w_grant_rd ? 1'b0 : r_ar_full);

`ifdef AXI4LITE_CSR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Count edges with csr_req high; restarts from zero while no request is out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if (!r_csr_req) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else begin
            r_tmo_cnt <= r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
        end
    end

    assign w_tmo_expire = r_csr_req && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_expire = 1'b0;
`endif

    // A real ack always wins over a simultaneous timeout expiry.
    assign w_fin    = csr_ack | w_tmo_expire;
    assign w_slverr = csr_ack ? csr_err : 1'b1;

    // AW/W/AR holding registers and their registered READYs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_ar_full <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_aw_addr <= {(CSR_ADDR_WIDTH-2){1'b0}};
            r_ar_addr <= {(CSR_ADDR_WIDTH-2){1'b0}};
            r_w_data  <= {DATA_WIDTH{1'b0}};
            r_w_strb  <= {STRB_W{1'b0}};
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_ar_full <= w_ar_full_nxt;
            r_awready <= ~w_aw_full_nxt;
            r_wready  <= ~w_w_full_nxt;
            r_arready <= ~w_ar_full_nxt;
            if (w_aw_cap) r_aw_addr <= s_awaddr[CSR_ADDR_WIDTH-1:2];
            if (w_ar_cap) r_ar_addr <= s_araddr[CSR_ADDR_WIDTH-1:2];
            if (w_w_cap) begin
                r_w_data <= s_wdata;
                r_w_strb <= s_wstrb;
            end
        end
    end

    // Transaction FSM: grant, CSR request/ack, then hold the AXI response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_prio_rd     <= 1'b0;
            r_csr_req     <= 1'b0;
            r_csr_is_wr   <= 1'b0;
            r_csr_addr    <= {CSR_ADDR_WIDTH{1'b0}};
            r_csr_wr_data <= {DATA_WIDTH{1'b0}};
            r_csr_biten   <= {DATA_WIDTH{1'b0}};
            r_bvalid      <= 1'b0;
            r_rvalid      <= 1'b0;
            r_bresp       <= 2'b00;
            r_rresp       <= 2'b00;
            r_rdata       <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_wr) begin
                        r_state       <= ST_CSR_WR;
                        r_csr_req     <= 1'b1;
                        r_csr_is_wr   <= 1'b1;
                        r_csr_addr    <= {r_aw_addr, 2'b00};
                        r_csr_wr_data <= r_w_data;
                        r_csr_biten   <= f_strb_to_biten(r_w_strb);
                        if (w_rd_pend) r_prio_rd <= 1'b1;
                    end else if (w_grant_rd) begin
                        r_state       <= ST_CSR_RD;
                        r_csr_req     <= 1'b1;
                        r_csr_is_wr   <= 1'b0;
                        r_csr_addr    <= {r_ar_addr, 2'b00};
                        r_csr_wr_data <= {DATA_WIDTH{1'b0}};
                        r_csr_biten   <= {DATA_WIDTH{1'b0}};
                        if (w_wr_pend) r_prio_rd <= 1'b0;
                    end
                end
                ST_CSR_WR, ST_CSR_RD: begin
                    if (w_fin) begin
                        r_csr_req <= 1'b0;
                        if (r_state == ST_CSR_WR) begin
                            r_state  <= ST_WR_RESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_slverr ? 2'b10 : 2'b00;
                        end else begin
                            r_state  <= ST_RD_RESP;
                            r_rvalid <= 1'b1;
                            r_rresp  <= w_slverr ? 2'b10 : 2'b00;
                            r_rdata  <= w_slverr ? {DATA_WIDTH{1'b0}} : csr_rd_data;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (s_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RD_RESP: begin
                    if (s_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_csr_req <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign s_awready     = r_awready;
    assign s_wready      = r_wready;
    assign s_arready     = r_arready;
    assign s_bvalid      = r_bvalid;
    assign s_bresp       = r_bresp;
    assign s_rvalid      = r_rvalid;
    assign s_rresp       = r_rresp;
    assign s_rdata       = r_rdata;
    assign csr_req       = r_csr_req;
    assign csr_req_is_wr = r_csr_is_wr;
    assign csr_addr      = r_csr_addr;
    assign csr_wr_data   = r_csr_wr_data;
    assign csr_wr_biten  = r_csr_biten;

    // PROT and the sub-word address bits carry no meaning for the CSR side.
    logic w_unused;
    assign w_unused = &{1'b0, s_awprot, s_arprot, s_awaddr[1:0], s_araddr[1:0],
                        (TIMEOUT_CYCLES > 1)};

endmodule

// File: tb/tb_axi4lite_csr_adapter.sv
// Testbench for axi4lite_csr_adapter: directed scenarios followed by random
// single transactions, checked against a word-array model of the CSR space.
module tb_axi4lite_csr_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic        csr_req, csr_req_is_wr, csr_ack, csr_err;
    logic [31:0] csr_addr, csr_wr_data, csr_wr_biten, csr_rd_data;

    always #5 clk = ~clk;

    axi4lite_csr_adapter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .CSR_ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .csr_req(csr_req), .csr_req_is_wr(csr_req_is_wr), .csr_addr(csr_addr),
        .csr_wr_data(csr_wr_data), .csr_wr_biten(csr_wr_biten),
        .csr_ack(csr_ack), .csr_err(csr_err), .csr_rd_data(csr_rd_data)
    );

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; logic [31:0] biten; } req_t;
    req_t        req_q[$];
    int          total = 0;
    int          bad = 0;
    int          ack_lat = 1;
    logic        ack_err = 1'b0;
    logic        force_ack = 1'b0;
    int          rcnt = 0;
    int          last_len = 0;
    logic [31:0] rsp_mem [4];
    logic [31:0] ref_mem [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // CSR register block stand-in: acks after ack_lat cycles of csr_req, logs requests.
    initial begin
        csr_ack = 1'b0; csr_err = 1'b0; csr_rd_data = 32'd0;
        for (int i = 0; i < 4; i++) rsp_mem[i] = 32'd0;
        forever begin
            @(negedge clk);
            if (csr_req) begin
                if (rcnt == 0)
                    req_q.push_back('{wr: csr_req_is_wr, addr: csr_addr, data: csr_wr_data, biten: csr_wr_biten});
                if (rcnt == ack_lat - 1) begin
                    csr_ack = 1'b1;
                    csr_err = ack_err;
                    if (csr_req_is_wr) begin
                        csr_rd_data = 32'd0;
                        if (!ack_err)
                            rsp_mem[csr_addr[3:2]] = (rsp_mem[csr_addr[3:2]] & ~csr_wr_biten) |
                                                     (csr_wr_data & csr_wr_biten);
                    end else begin
                        csr_rd_data = ack_err ? 32'hDEAD_BEEF : rsp_mem[csr_addr[3:2]];
                    end
                end else begin
                    csr_ack = force_ack;
                    csr_err = 1'b0;
                end
                rcnt++;
            end else begin
                if (rcnt > 0) last_len = rcnt;
                rcnt = 0;
                csr_ack = force_ack;
                csr_err = 1'b0;
                csr_rd_data = 32'd0;
            end
        end
    end

    function automatic logic [31:0] exp_biten(input logic [3:0] s);
        logic [31:0] b;
        b = 32'd0;
        for (int i = 0; i < 4; i++) if (s[i]) b = b | (32'hFF << (8 * i));
        return b;
    endfunction

    // Model: a write updates only the strobed bytes of its word.
    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = ref_mem[a[3:2]];
        for (int i = 0; i < 4; i++)
            if (s[i]) w = (w & ~(32'hFF << (8 * i))) | (d & (32'hFF << (8 * i)));
        ref_mem[a[3:2]] = w;
    endtask

    // Present selected AXI address/data channels together; drop each on its handshake.
    task automatic drive(input logic aw, input logic w, input logic ar, input logic [31:0] awa,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ara);
        logic aw_hs, w_hs, ar_hs;
        int n;
        @(negedge clk);
        s_awaddr = awa; s_awvalid = aw; s_wdata = wd; s_wstrb = ws; s_wvalid = w;
        s_araddr = ara; s_arvalid = ar;
        n = 0;
        while ((s_awvalid || s_wvalid || s_arvalid) && n < 100) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            ar_hs = s_arvalid && s_arready;
            @(negedge clk);
            n++;
            if (aw_hs) s_awvalid = 1'b0;
            if (w_hs)  s_wvalid = 1'b0;
            if (ar_hs) s_arvalid = 1'b0;
        end
        chk("handshake_done", 32'(s_awvalid || s_wvalid || s_arvalid), 32'd0);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    endtask

    task automatic wait_b(input string tag, input int hold, input logic [1:0] er);
        int n;
        n = 0;
        while (!s_bvalid && n < 300) begin @(negedge clk); n++; end
        chk({tag, "_bvalid"}, 32'(s_bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(s_bresp), 32'(er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_bhold_valid"}, 32'(s_bvalid), 32'd1);
            chk({tag, "_bhold_resp"}, 32'(s_bresp), 32'(er));
            chk({tag, "_bhold_noreq"}, 32'(csr_req), 32'd0);
        end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        chk({tag, "_bdone"}, 32'(s_bvalid), 32'd0);
    endtask

    task automatic wait_r(input string tag, input int hold, input logic [31:0] ed, input logic [1:0] er);
        int n;
        n = 0;
        while (!s_rvalid && n < 300) begin @(negedge clk); n++; end
        chk({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
        chk({tag, "_rresp"}, 32'(s_rresp), 32'(er));
        chk({tag, "_rdata"}, s_rdata, ed);
        chk({tag, "_one_valid"}, 32'(s_bvalid), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_rhold_valid"}, 32'(s_rvalid), 32'd1);
            chk({tag, "_rhold_data"}, s_rdata, ed);
            chk({tag, "_rhold_noreq"}, 32'(csr_req), 32'd0);
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        chk({tag, "_rdone"}, 32'(s_rvalid), 32'd0);
    endtask

    task automatic check_req(input string tag, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] be);
        req_t r;
        chk({tag, "_present"}, 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) begin
            r = req_q.pop_front();
            chk({tag, "_is_wr"}, 32'(r.wr), 32'(wr));
            chk({tag, "_addr"}, r.addr, a);
            if (wr) begin
                chk({tag, "_wdata"}, r.data, d);
                chk({tag, "_biten"}, r.biten, be);
            end
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lat, input logic err, input int hold);
        ack_lat = lat; ack_err = err;
        drive(1'b1, 1'b1, 1'b0, a, d, s, 32'd0);
        wait_b(tag, hold, err ? 2'b10 : 2'b00);
        check_req(tag, 1'b1, a & 32'hFFFF_FFFC, d, exp_biten(s));
        if (!err) ref_write(a, d, s);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input int lat,
                           input logic err, input int hold);
        logic [31:0] e;
        e = err ? 32'd0 : ref_mem[a[3:2]];
        ack_lat = lat; ack_err = err;
        drive(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, a);
        wait_r(tag, hold, e, err ? 2'b10 : 2'b00);
        check_req(tag, 1'b0, a & 32'hFFFF_FFFC, 32'd0, 32'd0);
    endtask

    logic [31:0] ra, rd, er1, er2;
    logic [3:0]  rs;
    int          n;

    initial begin
        rst = 1'b0;
        s_awaddr = 32'd0; s_awprot = 3'd0; s_awvalid = 1'b0;
        s_wdata = 32'd0; s_wstrb = 4'd0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = 32'd0; s_arprot = 3'd0; s_arvalid = 1'b0; s_rready = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_wready", 32'(s_wready), 32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_csr_req", 32'(csr_req), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_csr_addr", csr_addr, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_awready_before_edge", 32'(s_awready), 32'd0);
        @(negedge clk);
        chk("rel_awready", 32'(s_awready), 32'd1);
        chk("rel_wready", 32'(s_wready), 32'd1);
        chk("rel_arready", 32'(s_arready), 32'd1);

        // 1: AW+W together, ack in the first csr_req cycle
        ack_lat = 1; ack_err = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'h0000_00EF, 4'hF, 32'd0);
        chk("t1_req_k", 32'(csr_req), 32'd0);
        chk("t1_awready_drop", 32'(s_awready), 32'd0);
        @(negedge clk);
        chk("t1_req_k1", 32'(csr_req), 32'd1);
        chk("t1_is_wr", 32'(csr_req_is_wr), 32'd1);
        chk("t1_addr", csr_addr, 32'h4000_0000);
        chk("t1_wdata", csr_wr_data, 32'h0000_00EF);
        chk("t1_biten", csr_wr_biten, 32'hFFFF_FFFF);
        chk("t1_bvalid_k1", 32'(s_bvalid), 32'd0);
        chk("t1_awready_reopen", 32'(s_awready), 32'd1);
        @(negedge clk);
        chk("t1_bvalid_k2", 32'(s_bvalid), 32'd1);
        chk("t1_bresp", 32'(s_bresp), 32'd0);
        chk("t1_req_done", 32'(csr_req), 32'd0);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        chk("t1_bdone", 32'(s_bvalid), 32'd0);
        void'(req_q.pop_front());
        ref_write(32'h4000_0000, 32'h0000_00EF, 4'hF);

        // 2: read with 3-cycle ack
        do_read("t2", 32'h4000_0000, 3, 1'b0, 0);
        chk("t2_req_len", 32'(last_len), 32'd3);

        // 3: W four cycles ahead of AW
        ack_lat = 1; ack_err = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h1234_5678, 4'b0001, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_no_req_without_aw", 32'(csr_req), 32'd0);
        end
        chk("t3_wready_held", 32'(s_wready), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h4000_0004, 32'd0, 4'd0, 32'd0);
        wait_b("t3", 0, 2'b00);
        check_req("t3", 1'b1, 32'h4000_0004, 32'h1234_5678, 32'h0000_00FF);
        chk("t3_single_req", 32'(req_q.size()), 32'd0);
        ref_write(32'h4000_0004, 32'h1234_5678, 4'b0001);

        // 4: write and read pending together, twice
        ack_lat = 2; ack_err = 1'b0;
        er1 = ref_mem[3];
        drive(1'b1, 1'b1, 1'b1, 32'h4000_0008, 32'hCAFE_0001, 4'hF, 32'h4000_000C);
        ref_write(32'h4000_0008, 32'hCAFE_0001, 4'hF);
        wait_b("t4a", 5, 2'b00);
        wait_r("t4a", 0, er1, 2'b00);
        check_req("t4a_first", 1'b1, 32'h4000_0008, 32'hCAFE_0001, 32'hFFFF_FFFF);
        check_req("t4a_second", 1'b0, 32'h4000_000C, 32'd0, 32'd0);
        er2 = ref_mem[2];
        drive(1'b1, 1'b1, 1'b1, 32'h4000_000C, 32'h0BAD_F00D, 4'b0011, 32'h4000_0008);
        wait_r("t4b", 2, er2, 2'b00);
        wait_b("t4b", 0, 2'b00);
        ref_write(32'h4000_000C, 32'h0BAD_F00D, 4'b0011);
        check_req("t4b_first", 1'b0, 32'h4000_0008, 32'd0, 32'd0);
        check_req("t4b_second", 1'b1, 32'h4000_000C, 32'h0BAD_F00D, 32'h0000_FFFF);

        // 5: error read, then stray acks while idle
        do_read("t5_err", 32'h4000_0008, 2, 1'b1, 1);
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        chk("t5_stray_bvalid", 32'(s_bvalid), 32'd0);
        chk("t5_stray_rvalid", 32'(s_rvalid), 32'd0);
        chk("t5_stray_req", 32'(csr_req), 32'd0);
        do_read("t5_after_stray", 32'h4000_000C, 1, 1'b0, 0);
`ifdef AXI4LITE_CSR_TIMEOUT_EN
        do_write("t5_tmo", 32'h4000_0004, 32'h5555_AAAA, 4'hF, 1000, 1'b1, 0);
        chk("t5_tmo_req_len", 32'(last_len), 32'd8);
        ack_err = 1'b0;
`endif

        // 6: reset while in CSR_WR
        ack_lat = 100; ack_err = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h4000_0004, 32'hA5A5_A5A5, 4'hF, 32'd0);
        n = 0;
        while (!csr_req && n < 20) begin @(negedge clk); n++; end
        chk("t6_req_up", 32'(csr_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_req", 32'(csr_req), 32'd0);
        chk("t6_bvalid", 32'(s_bvalid), 32'd0);
        chk("t6_awready", 32'(s_awready), 32'd0);
        chk("t6_wready", 32'(s_wready), 32'd0);
        chk("t6_arready", 32'(s_arready), 32'd0);
        chk("t6_addr", csr_addr, 32'd0);
        req_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_awready_back", 32'(s_awready), 32'd1);
        chk("t6_wready_back", 32'(s_wready), 32'd1);
        chk("t6_arready_back", 32'(s_arready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_stale_bvalid", 32'(s_bvalid), 32'd0);
            chk("t6_no_req", 32'(csr_req), 32'd0);
        end

        // Random single transactions against the model
        for (int it = 0; it < 30; it++) begin
            ra = 32'h4000_0000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            rd = $urandom;
            rs = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                do_write("rnd_wr", ra, rd, rs, $urandom_range(1, 4), ($urandom_range(0, 7) == 0),
                         $urandom_range(0, 3));
            else
                do_read("rnd_rd", ra, $urandom_range(1, 4), ($urandom_range(0, 7) == 0),
                        $urandom_range(0, 3));
        end
        ack_err = 1'b0;
        for (int i = 0; i < 4; i++)
            do_read("final_rd", 32'h4000_0000 + 32'(i * 4), 1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
